// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick conditioner: repeat states,
// button bit indices and the opposing-direction (SOCD) pair list.
package joy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } rpt_state_e;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  // Pair k is made of entries 2k and 2k+1.
  localparam int SOCD_NUM_PAIRS = 2;
  localparam logic [2*SOCD_NUM_PAIRS-1:0][7:0] SOCD_PAIRS = {
    8'(BTN_UP), 8'(BTN_DOWN), 8'(BTN_LEFT), 8'(BTN_RIGHT)
  };

  // Opposing bit for idx, or -1 when idx belongs to no pair.
  function automatic int socd_partner(input int idx);
    int p;
    p = -1;
    for (int k = 0; k < SOCD_NUM_PAIRS; k++) begin
      if (idx == int'(SOCD_PAIRS[2*k])) begin
        p = int'(SOCD_PAIRS[2*k+1]);
      end else if (idx == int'(SOCD_PAIRS[2*k+1])) begin
        p = int'(SOCD_PAIRS[2*k]);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/joy_btn_channel.sv
// One button channel: tick-sampled debounce, press/release events and the
// autorepeat FSM (built only when JOY_AUTOREPEAT_EN is defined).
module joy_btn_channel
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_TICKS      = 5,
  parameter int REPEAT_DELAY_TICKS  = 400,
  parameter int REPEAT_PERIOD_TICKS = 80,
  parameter bit REPEAT_ON           = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sync_bit,
  input  logic repeat_en,
  input  logic lock,
  output logic held_next,
  output logic held,
  output logic press,
  output logic released
);

  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [DEB_W-1:0] deb_cnt_r;
  logic             held_r;
  logic             press_r;
  logic             released_r;
  logic             diff_s;
  logic             toggle_s;
  logic             rise_s;
  logic             fall_s;
  logic             rpt_pulse_s;

  assign diff_s    = sync_bit != held_r;
  assign toggle_s  = tick && diff_s && (deb_cnt_r == DEB_W'(DEBOUNCE_TICKS - 1));
  assign held_next = held_r ^ toggle_s;
  assign rise_s    = toggle_s & ~held_r;
  assign fall_s    = toggle_s & held_r;

  // Debounce counter: counts consecutive disagreeing ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_r <= '0;
    end else if (tick) begin
      if (diff_s && !toggle_s) begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end else begin
        deb_cnt_r <= '0;
      end
    end else begin
      deb_cnt_r <= deb_cnt_r;
    end
  end

  // Registered level and one-cycle events; SOCD lock only gates presses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_r     <= 1'b0;
      press_r    <= 1'b0;
      released_r <= 1'b0;
    end else begin
      held_r     <= held_next;
      press_r    <= (rise_s & ~lock) | rpt_pulse_s;
      released_r <= fall_s;
    end
  end

`ifdef JOY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  rpt_state_e       state_r, state_s;
  logic [RPT_W-1:0] cnt_r, cnt_s;

  // Repeat state and countdown registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Release wins over everything; lock or a dropped enable parks in HOLD.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    rpt_pulse_s = 1'b0;
    if (fall_s || !REPEAT_ON) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            if (lock || !repeat_en) begin
              state_s = ST_HOLD;
            end else begin
              state_s = ST_DELAY;
              cnt_s   = RPT_W'(REPEAT_DELAY_TICKS);
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (lock || !repeat_en) begin
            state_s = ST_HOLD;
          end else if (tick) begin
            if (cnt_r == RPT_W'(1)) begin
              rpt_pulse_s = 1'b1;
              cnt_s       = RPT_W'(REPEAT_PERIOD_TICKS);
              state_s     = ST_REPEAT;
            end else begin
              cnt_s = cnt_r - RPT_W'(1);
            end
          end else begin
            state_s = state_r;
          end
        end
        ST_HOLD: state_s = ST_HOLD;
        default: state_s = ST_IDLE;
      endcase
    end
  end
`else
  logic unused_s;
  assign unused_s    = repeat_en ^ REPEAT_ON ^ (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS);
  assign rpt_pulse_s = 1'b0;
`endif

  assign held     = held_r;
  assign press    = press_r;
  assign released = released_r;

endmodule

// File: rtl/joy_autorepeat.sv
// Joystick conditioner top: 2-FF synchronisers, tick divider, SOCD lockout and
// one joy_btn_channel per bit. Autorepeat is built under JOY_AUTOREPEAT_EN.
module joy_autorepeat
  import joy_pkg::*;
#(
  parameter int                 NUM_BTN             = 16,
  parameter int                 TICK_DIV            = 50000,
  parameter int                 DEBOUNCE_TICKS      = 5,
  parameter int                 REPEAT_DELAY_TICKS  = 400,
  parameter int                 REPEAT_PERIOD_TICKS = 80,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK         = 16'h000F
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] joy_raw,
  input  logic               repeat_en,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] press,
  // "release" is a reserved word, hence the event name.
  output logic [NUM_BTN-1:0] released
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt_r;
  logic               tick_s;
  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [NUM_BTN-1:0] held_next_s;
  logic [NUM_BTN-1:0] lock_s;

  assign tick_s = div_cnt_r == DIV_W'(TICK_DIV - 1);

  // Free-running tick divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Two-stage synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= joy_raw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    localparam int PARTNER = socd_partner(i);

    // Lock uses next-cycle levels so a simultaneous press is caught too.
    if (PARTNER >= 0 && PARTNER < NUM_BTN) begin : g_socd
      assign lock_s[i] = held_next_s[i] & held_next_s[PARTNER];
    end else begin : g_free
      assign lock_s[i] = 1'b0;
    end

    joy_btn_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .REPEAT_ON           (REPEAT_MASK[i])
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick_s),
      .sync_bit  (sync2_r[i]),
      .repeat_en (repeat_en),
      .lock      (lock_s[i]),
      .held_next (held_next_s[i]),
      .held      (held[i]),
      .press     (press[i]),
      .released  (released[i])
    );
  end

endmodule

// File: tb/tb_joy_autorepeat.sv
// Scoreboard bench for joy_autorepeat: a tick-level reference model queues
// expected events, a negedge monitor matches DUT pulses against the queue.
module tb_joy_autorepeat;

  localparam int          NB   = 16;
  localparam int          TDIV = 4;
  localparam int          DEB  = 3;
  localparam int          DLY  = 5;
  localparam int          PER  = 2;
  localparam logic [15:0] MASK = 16'h000F;
`ifdef JOY_AUTOREPEAT_EN
  localparam bit RPT_BUILT = 1'b1;
`else
  localparam bit RPT_BUILT = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          repeat_en = 1'b1;
  logic [NB-1:0] joy_raw   = '1;
  logic [NB-1:0] held, press, released;

  always #5 clk = ~clk;

  joy_autorepeat #(
    .NUM_BTN(NB), .TICK_DIV(TDIV), .DEBOUNCE_TICKS(DEB),
    .REPEAT_DELAY_TICKS(DLY), .REPEAT_PERIOD_TICKS(PER), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .joy_raw(joy_raw), .repeat_en(repeat_en),
    .held(held), .press(press), .released(released)
  );

  typedef struct {int cyc; int kind; int idx;} ev_t;
  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // ---------------- reference model ----------------
  logic [NB-1:0] m_s1 = '0, m_s2 = '0, m_held = '0;
  logic [NB-1:0] nh, lk;
  int  m_diff[NB];
  bit  m_armed[NB];
  int  m_age[NB];
  int  ncyc = 0;
  bit  tk, pr, rise, fall;

  function automatic int partner(input int i);
    if (i < 4) return i ^ 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; ncyc = 0;
      for (int i = 0; i < NB; i++) begin
        m_diff[i] = 0; m_armed[i] = 0; m_age[i] = 0;
      end
    end else begin
      tk = (ncyc % TDIV) == TDIV - 1;
      ncyc++;
      nh = m_held;
      if (tk) begin
        for (int i = 0; i < NB; i++) begin
          if (m_s2[i] != m_held[i]) begin
            m_diff[i]++;
            if (m_diff[i] == DEB) begin
              nh[i] = ~nh[i];
              m_diff[i] = 0;
            end
          end else begin
            m_diff[i] = 0;
          end
        end
      end
      for (int i = 0; i < NB; i++)
        lk[i] = (partner(i) >= 0) && nh[i] && nh[partner(i)];
      for (int i = 0; i < NB; i++) begin
        rise = nh[i] && !m_held[i];
        fall = !nh[i] && m_held[i];
        pr = 0;
        if (rise) begin
          pr = !lk[i];
          m_armed[i] = RPT_BUILT && MASK[i] && repeat_en && !lk[i];
          m_age[i] = 0;
        end else if (fall) begin
          m_armed[i] = 0;
        end else if (m_armed[i]) begin
          if (lk[i] || !repeat_en) begin
            m_armed[i] = 0;
          end else if (tk) begin
            m_age[i]++;
            if (m_age[i] >= DLY && (m_age[i] - DLY) % PER == 0) pr = 1;
          end
        end
        if (pr)   exp_q.push_back('{cyc, 0, i});
        if (fall) exp_q.push_back('{cyc, 1, i});
      end
      m_held = nh;
      m_s2 = m_s1;
      m_s1 = joy_raw;
    end
  end

  // ---------------- monitor ----------------
  int press_cnt[NB];
  int rel_cnt[NB];
  int p3_q[$];
  int rel3 = -1;

  task automatic match_ev(input int kind, input int idx);
    int hit;
    hit = -1;
    tests++;
    for (int j = 0; j < exp_q.size(); j++)
      if (hit < 0 && exp_q[j].cyc == cyc && exp_q[j].kind == kind && exp_q[j].idx == idx) hit = j;
    if (hit >= 0) exp_q.delete(hit);
    else begin
      fails++;
      $display("FAIL unexpected_%s bit %0d at cycle %0d: DUT pulsed, model expected none",
               kind == 0 ? "press" : "release", idx, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      tests++; fails++;
      $display("FAIL missed_%s bit %0d: expected at cycle %0d, still absent at cycle %0d",
               exp_q[0].kind == 0 ? "press" : "release", exp_q[0].idx, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < NB; i++) begin
      if (press[i]) begin
        match_ev(0, i);
        press_cnt[i]++;
        if (i == 3) p3_q.push_back(cyc);
      end
      if (released[i]) begin
        match_ev(1, i);
        rel_cnt[i]++;
        if (i == 3) rel3 = cyc;
      end
    end
    tests++;
    if (held !== m_held) begin
      fails++;
      $display("FAIL held at cycle %0d: got %h expected %h", cyc, held, m_held);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0;
    end
    p3_q.delete();
    rel3 = -1;
  endtask

  initial begin
    clr_cnt();
    // Reset with every raw input high.
    step(5);
    chk("reset_held", held, 0);
    chk("reset_press", press, 0);
    chk("reset_release", released, 0);
    joy_raw = '0;
    step(2);
    reset_n = 1'b1;
    step(10);

    // Unmasked bit 4: one press, held within 2 cycles + 3 ticks (+ alignment).
    clr_cnt();
    joy_raw[4] = 1'b1;
    step(20);
    chk("press4_held", held[4], 1);
    step(40);
    chk("press4_count", press_cnt[4], 1);
    joy_raw[4] = 1'b0;
    step(30);
    chk("release4_count", rel_cnt[4], 1);

    // Glitch of two ticks on bit 0.
    clr_cnt();
    joy_raw[0] = 1'b1;
    step(2 * TDIV);
    joy_raw[0] = 1'b0;
    step(30);
    chk("glitch_press0", press_cnt[0], 0);

    // Autorepeat on bit 3.
    clr_cnt();
    joy_raw[3] = 1'b1;
    step(100);
    joy_raw[3] = 1'b0;
    step(40);
    chk("ar_count_ok", RPT_BUILT ? (p3_q.size() >= 5) : (p3_q.size() == 1), 1);
    for (int k = 1; k < p3_q.size(); k++)
      chk("ar_gap", p3_q[k] - p3_q[k-1], (k == 1) ? DLY * TDIV : PER * TDIV);
    chk("ar_release_count", rel_cnt[3], 1);
    if (p3_q.size() > 0) chk("ar_no_press_after_release", p3_q[p3_q.size()-1] < rel3, 1);

    // SOCD: bit 1 then bit 0.
    clr_cnt();
    joy_raw[1] = 1'b1;
    step(8);
    joy_raw[0] = 1'b1;
    step(60);
    chk("socd_press0", press_cnt[0], 0);
    chk("socd_press1", press_cnt[1], 1);
    joy_raw[1] = 1'b0;
    step(60);
    chk("socd_after_release_press0", press_cnt[0], 0);
    joy_raw[0] = 1'b0;
    step(30);
    clr_cnt();
    joy_raw[0] = 1'b1;
    step(60);
    chk("socd_repress_ok", RPT_BUILT ? (press_cnt[0] >= 3) : (press_cnt[0] == 1), 1);
    joy_raw[0] = 1'b0;
    step(30);

    // repeat_en dropped during DELAY.
    clr_cnt();
    joy_raw[2] = 1'b1;
    step(24);
    repeat_en = 1'b0;
    step(8);
    repeat_en = 1'b1;
    step(60);
    chk("en_drop_press2", press_cnt[2], 1);
    joy_raw[2] = 1'b0;
    step(30);

    // Reset while bit 5 is held, then re-press after full debounce.
    clr_cnt();
    joy_raw[5] = 1'b1;
    step(30);
    chk("midreset_held_before", held[5], 1);
    reset_n = 1'b0;
    #1;
    chk("midreset_held_cleared", held, 0);
    step(3);
    reset_n = 1'b1;
    step(40);
    chk("midreset_repress_held", held[5], 1);
    chk("midreset_press_count", press_cnt[5], 2);
    joy_raw[5] = 1'b0;
    step(30);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) joy_raw[$urandom_range(0, NB-1)] ^= 1'b1;
      if ($urandom_range(0, 5) == 0) joy_raw[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
      step(1);
    end
    repeat_en = 1'b1;
    joy_raw = '0;
    step(80);
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
